sw_debouncer: RTL and testbench

//   Conditions the four active-low push switches before they reach gpio_pin_in of the GPIO block.
//   For each switch it provides:
//     - 2-flop synchronisation into the clk_pix domain;
//     - counter-based debounce;
//     - one-cycle press, release and auto-repeat pulses;
//     - a per-switch sticky event flag that firmware clears through GPIO output bits.

---
 rtl/sw_debouncer_pkg.sv | 28 ++
 rtl/sw_debouncer_if.sv | 35 +++
 rtl/sw_debounce_ch.sv | 150 +++++++++++++++
 rtl/sw_debouncer.sv | 57 +++++
 tb/tb_sw_debouncer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sw_debouncer_pkg.sv
// sw_debouncer_pkg: shared FSM states, default timing and width helper
// for the push-switch debouncer channels.
package sw_debouncer_pkg;

  typedef enum logic [1:0] {
    UP     = 2'd0,
    CHK_DN = 2'd1,
    DN     = 2'd2,
    CHK_UP = 2'd3
  } sw_state_e;

  // 5 ms debounce, 0.5 s first repeat, 0.1 s repeat period at 74.25 MHz.
  localparam int unsigned DEF_NSW           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC  = 371250;
  localparam int unsigned DEF_REPEAT_DELAY  = 37125000;
  localparam int unsigned DEF_REPEAT_PERIOD = 7425000;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    if (n > 1) begin
      return $clog2(n);
    end
    return 1;
  endfunction

endpackage

// File: rtl/sw_debouncer_if.sv
// sw_debouncer_if: switch pins, sticky clears and conditioned outputs.
// master = switch/GPIO side, slave = debouncer.
interface sw_debouncer_if #(
  parameter int unsigned NSW = 4
);

  logic [NSW-1:0] sw_n_in;
  logic [NSW-1:0] evt_clr;
  logic [NSW-1:0] sw_level;
  logic [NSW-1:0] sw_press;
  logic [NSW-1:0] sw_release;
  logic [NSW-1:0] sw_repeat;
  logic [NSW-1:0] evt_sticky;

  modport master (
    output sw_n_in,
    output evt_clr,
    input  sw_level,
    input  sw_press,
    input  sw_release,
    input  sw_repeat,
    input  evt_sticky
  );

  modport slave (
    input  sw_n_in,
    input  evt_clr,
    output sw_level,
    output sw_press,
    output sw_release,
    output sw_repeat,
    output evt_sticky
  );

endinterface

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: one switch channel - 2-flop sync, debounce FSM,
// registered level and press/release/repeat pulses (active high).
module sw_debounce_ch
  import sw_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_pix,
  input  logic rst_n,
  input  logic sw_n_in,
  output logic sw_level,
  output logic sw_press,
  output logic sw_release,
  output logic sw_repeat
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYC);
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW = cnt_w(RMAX);
  localparam bit REP_EN = (REPEAT_DELAY != 0);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYC - 1);
  localparam logic [RCW-1:0] RDLY_LAST =
    RCW'(REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [RCW-1:0] RPER_LAST =
    RCW'(REPEAT_PERIOD - 1);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  sw_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  // 0: counting towards first repeat, 1: periodic repeats.
  logic rphase_q, rphase_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic repeat_q, repeat_d;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      // Sync flops come up holding the released level.
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= UP;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      rphase_q  <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      rphase_q  <= rphase_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    s1_d      = ~sw_n_in;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    rphase_d  = rphase_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      UP: begin
        if (s2_q) begin
          state_d = CHK_DN;
          cnt_d   = '0;
        end
      end
      CHK_DN: begin
        if (!s2_q) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DN;
          cnt_d    = '0;
          level_d  = 1'b1;
          press_d  = 1'b1;
          rcnt_d   = '0;
          rphase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DN: begin
        if (!s2_q) begin
          state_d = CHK_UP;
          cnt_d   = '0;
        end else if (REP_EN) begin
          if (!rphase_q) begin
            if (rcnt_q == RDLY_LAST) begin
              repeat_d = 1'b1;
              rcnt_d   = '0;
              rphase_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end else begin
            if (rcnt_q == RPER_LAST) begin
              repeat_d = 1'b1;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
      end
      CHK_UP: begin
        // rcnt holds so a bounce back to DN resumes the repeat timing.
        if (s2_q) begin
          state_d = DN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = UP;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign sw_level   = level_q;
  assign sw_press   = press_q;
  assign sw_release = release_q;
  assign sw_repeat  = repeat_q;

endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer: NSW debounced switch channels plus per-channel sticky
// event flags (set by press/repeat, cleared by evt_clr; set wins).
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int unsigned NSW           = DEF_NSW,
  parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic           clk_pix,
  input  logic           rst_n,
  sw_debouncer_if.slave  bus
);

  logic [NSW-1:0] level;
  logic [NSW-1:0] press;
  logic [NSW-1:0] release_p;
  logic [NSW-1:0] rpt;
  logic [NSW-1:0] evt_sticky_q, evt_sticky_d;

  for (genvar i = 0; i < NSW; i++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk_pix    (clk_pix),
      .rst_n      (rst_n),
      .sw_n_in    (bus.sw_n_in[i]),
      .sw_level   (level[i]),
      .sw_press   (press[i]),
      .sw_release (release_p[i]),
      .sw_repeat  (rpt[i])
    );
  end

  always_comb begin
    evt_sticky_d = (evt_sticky_q & ~bus.evt_clr)
                 | press | rpt;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      evt_sticky_q <= '0;
    end else begin
      evt_sticky_q <= evt_sticky_d;
    end
  end

  assign bus.sw_level   = level;
  assign bus.sw_press   = press;
  assign bus.sw_release = release_p;
  assign bus.sw_repeat  = rpt;
  assign bus.evt_sticky = evt_sticky_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// tb_sw_debouncer: directed stimulus with expected events/state pushed
// into queues and checked by a separate negedge monitor.
module tb_sw_debouncer;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;

  sw_debouncer_if #(.NSW(4)) bus ();

  sw_debouncer #(
    .NSW           (4),
    .DEBOUNCE_CYC  (8),
    .REPEAT_DELAY  (32),
    .REPEAT_PERIOD (16)
  ) dut (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int       cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
  } ev_t;

  typedef struct {
    int       cyc;
    logic [3:0] level;
    logic [3:0] sticky;
  } st_t;

  ev_t evq[$];
  st_t stq[$];

  task automatic exp_ev(input int c, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] q);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rep = q;
    evq.push_back(e);
  endtask

  task automatic exp_st(input int c, input logic [3:0] l,
                        input logic [3:0] s);
    st_t t;
    t.cyc = c; t.level = l; t.sticky = s;
    stq.push_back(t);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk_pix);
  endtask

  // Monitor: pops an expected event whenever the DUT pulses anything,
  // and compares state snapshots at their scheduled cycle.
  always @(negedge clk_pix) begin
    ev_t e;
    st_t t;
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      tests++; fails++;
      $display("FAIL missed_event cyc=%0d: got none, want p=%h r=%h q=%h",
               e.cyc, e.press, e.rel, e.rep);
    end
    if ((bus.sw_press | bus.sw_release | bus.sw_repeat) != 4'h0) begin
      tests++;
      if (evq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d: got p=%h r=%h q=%h, want none",
                 cyc, bus.sw_press, bus.sw_release, bus.sw_repeat);
      end else begin
        e = evq.pop_front();
        if (e.cyc != cyc || e.press != bus.sw_press ||
            e.rel != bus.sw_release || e.rep != bus.sw_repeat) begin
          fails++;
          $display("FAIL event cyc=%0d: got p=%h r=%h q=%h, want cyc=%0d p=%h r=%h q=%h",
                   cyc, bus.sw_press, bus.sw_release, bus.sw_repeat,
                   e.cyc, e.press, e.rel, e.rep);
        end
      end
    end
    while (stq.size() > 0 && stq[0].cyc <= cyc) begin
      t = stq.pop_front();
      tests++;
      if (t.cyc != cyc) begin
        fails++;
        $display("FAIL missed_state cyc=%0d", t.cyc);
      end else if (bus.sw_level != t.level ||
                   bus.evt_sticky != t.sticky) begin
        fails++;
        $display("FAIL state cyc=%0d: got lvl=%h stk=%h, want lvl=%h stk=%h",
                 cyc, bus.sw_level, bus.evt_sticky, t.level, t.sticky);
      end
    end
  end

  initial begin
    int c;
    bus.sw_n_in = 4'hF;
    bus.evt_clr = 4'h0;
    exp_st(2, 4'h0, 4'h0);
    wait_to(3);
    rst_n = 1'b1;
    wait_to(5);

    // ch0 press, repeats, release
    c = cyc;
    bus.sw_n_in[0] = 1'b0;
    exp_ev(c + 11, 4'h1, 4'h0, 4'h0);
    exp_st(c + 11, 4'h1, 4'h0);
    exp_st(c + 12, 4'h1, 4'h1);
    exp_ev(c + 43, 4'h0, 4'h0, 4'h1);
    exp_ev(c + 59, 4'h0, 4'h0, 4'h1);
    exp_ev(c + 75, 4'h0, 4'h0, 4'h1);
    wait_to(c + 80);
    bus.sw_n_in[0] = 1'b1;
    exp_ev(c + 91, 4'h0, 4'h1, 4'h0);
    exp_st(c + 91, 4'h0, 4'h1);
    wait_to(c + 100);
    bus.evt_clr = 4'hF;
    exp_st(c + 101, 4'h0, 4'h0);
    wait_to(c + 101);
    bus.evt_clr = 4'h0;

    // ch1 glitch shorter than the debounce window
    c = cyc;
    bus.sw_n_in[1] = 1'b0;
    wait_to(c + 5);
    bus.sw_n_in[1] = 1'b1;
    exp_st(c + 12, 4'h0, 4'h0);
    wait_to(c + 20);

    // ch2 sticky, clear, clear colliding with a repeat
    c = cyc;
    bus.sw_n_in[2] = 1'b0;
    exp_ev(c + 11, 4'h4, 4'h0, 4'h0);
    exp_st(c + 12, 4'h4, 4'h4);
    wait_to(c + 20);
    bus.evt_clr[2] = 1'b1;
    exp_st(c + 21, 4'h4, 4'h0);
    wait_to(c + 21);
    bus.evt_clr[2] = 1'b0;
    exp_st(c + 42, 4'h4, 4'h0);
    exp_ev(c + 43, 4'h0, 4'h0, 4'h4);
    wait_to(c + 43);
    bus.evt_clr[2] = 1'b1;
    exp_st(c + 44, 4'h4, 4'h4);
    wait_to(c + 44);
    bus.evt_clr[2] = 1'b0;
    exp_st(c + 45, 4'h4, 4'h4);
    wait_to(c + 50);
    bus.evt_clr[2] = 1'b1;
    exp_st(c + 51, 4'h4, 4'h0);
    wait_to(c + 51);
    bus.evt_clr[2] = 1'b0;
    wait_to(c + 52);
    bus.sw_n_in[2] = 1'b1;
    exp_ev(c + 63, 4'h0, 4'h4, 4'h0);
    exp_st(c + 63, 4'h0, 4'h0);
    wait_to(c + 70);

    // ch3 reset while held down
    c = cyc;
    bus.sw_n_in[3] = 1'b0;
    exp_ev(c + 11, 4'h8, 4'h0, 4'h0);
    exp_st(c + 12, 4'h8, 4'h8);
    wait_to(c + 20);
    rst_n = 1'b0;
    exp_st(c + 21, 4'h0, 4'h0);
    exp_st(c + 22, 4'h0, 4'h0);
    wait_to(c + 23);
    rst_n = 1'b1;
    exp_ev(c + 34, 4'h8, 4'h0, 4'h0);
    exp_st(c + 34, 4'h8, 4'h0);
    exp_st(c + 35, 4'h8, 4'h8);
    wait_to(c + 40);
    bus.sw_n_in[3] = 1'b1;
    exp_ev(c + 51, 4'h0, 4'h8, 4'h0);
    exp_st(c + 51, 4'h0, 4'h8);
    wait_to(c + 55);
    bus.evt_clr = 4'hF;
    exp_st(c + 56, 4'h0, 4'h0);
    wait_to(c + 56);
    bus.evt_clr = 4'h0;
    wait_to(c + 60);

    // all four channels on the same edge
    c = cyc;
    bus.sw_n_in = 4'h0;
    exp_ev(c + 11, 4'hF, 4'h0, 4'h0);
    exp_st(c + 11, 4'hF, 4'h0);
    exp_st(c + 12, 4'hF, 4'hF);
    wait_to(c + 20);
    bus.sw_n_in = 4'hF;
    exp_ev(c + 31, 4'h0, 4'hF, 4'h0);
    exp_st(c + 31, 4'h0, 4'hF);
    wait_to(c + 50);

    while (evq.size() > 0) begin
      ev_t e;
      e = evq.pop_front();
      tests++; fails++;
      $display("FAIL pending_event cyc=%0d: got none, want p=%h r=%h q=%h",
               e.cyc, e.press, e.rel, e.rep);
    end
    while (stq.size() > 0) begin
      st_t t;
      t = stq.pop_front();
      tests++; fails++;
      $display("FAIL pending_state cyc=%0d: got unchecked, want lvl=%h stk=%h",
               t.cyc, t.level, t.sticky);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
